// File: rtl/infifo_thread_scheduler.sv
// Packet scheduler between the input small FIFO and the per-thread input FIFOs.
// Grants free threads round-robin, steers whole packets to them and tracks busy state.
module infifo_thread_scheduler #(
    parameter int SEL_W       = 3,
    parameter int NUM_THREADS = 2**SEL_W,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pkt_valid,
    input  logic                   pkt_lastword,
    input  logic [NUM_THREADS-1:0] thread_done,
    output logic                   fifo_rd,
    output logic                   fifowrite_out,
    output logic                   firstword_out,
    output logic                   enable_cpu_out,
    output logic [SEL_W-1:0]       thread_sel,
    output logic [NUM_THREADS-1:0] thread_busy,
    output logic                   all_busy,
    output logic [CNT_W-1:0]       pkt_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        XFER     = 2'd2,
        DISPATCH = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SEL_W-1:0]       thread_sel_r;
    logic [SEL_W-1:0]       rr_ptr_r;
    logic [SEL_W-1:0]       free_idx_s;
    logic                   free_found_s;
    logic [NUM_THREADS-1:0] thread_busy_r;
    logic [NUM_THREADS-1:0] busy_nxt_s;
    logic                   all_busy_r;
    logic [CNT_W-1:0]       pkt_count_r;

    assign thread_sel  = thread_sel_r;
    assign thread_busy = thread_busy_r;
    assign all_busy    = all_busy_r;
    assign pkt_count   = pkt_count_r;

    // First free thread searching upward from rr_ptr+1; only registered busy is consulted.
    always_comb begin : rr_search
        logic [SEL_W-1:0] idx_v;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        idx_v        = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx_v = rr_ptr_r + SEL_W'(i);
            if (!free_found_s && !thread_busy_r[idx_v]) begin
                free_found_s = 1'b1;
                free_idx_s   = idx_v;
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt_s    = state_r;
        fifo_rd        = 1'b0;
        fifowrite_out  = 1'b0;
        firstword_out  = 1'b0;
        enable_cpu_out = 1'b0;
        case (state_r)
            IDLE: begin
                if (free_found_s) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READY: begin
                fifo_rd       = pkt_valid;
                fifowrite_out = pkt_valid;
                firstword_out = pkt_valid;
                if (pkt_valid && pkt_lastword) begin
                    state_nxt_s = DISPATCH;
                end else if (pkt_valid) begin
                    state_nxt_s = XFER;
                end else begin
                    state_nxt_s = READY;
                end
            end
            XFER: begin
                fifo_rd       = pkt_valid;
                fifowrite_out = pkt_valid;
                if (pkt_valid && pkt_lastword) begin
                    state_nxt_s = DISPATCH;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            DISPATCH: begin
                enable_cpu_out = 1'b1;
                state_nxt_s    = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Done pulses clear busy bits; a same-cycle dispatch to that thread wins.
    always_comb begin
        busy_nxt_s = thread_busy_r & ~thread_done;
        if (state_r == DISPATCH) begin
            busy_nxt_s[thread_sel_r] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // State, grant, round-robin pointer, busy flags and packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            thread_sel_r  <= '0;
            rr_ptr_r      <= '1;
            thread_busy_r <= '0;
            all_busy_r    <= 1'b0;
            pkt_count_r   <= '0;
        end else begin
            state_r       <= state_nxt_s;
            thread_busy_r <= busy_nxt_s;
            all_busy_r    <= &busy_nxt_s;
            if (state_r == IDLE && free_found_s) begin
                thread_sel_r <= free_idx_s;
            end
            if (state_r == DISPATCH) begin
                rr_ptr_r    <= thread_sel_r;
                pkt_count_r <= pkt_count_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_infifo_thread_scheduler.sv
// Scoreboard bench for infifo_thread_scheduler: a modelled small FIFO feeds packets,
// expected writes/enables are queued at stimulus time and matched as the DUT emits them.
module tb_infifo_thread_scheduler;

    localparam int SEL_W = 3;
    localparam int NT    = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pkt_valid = 1'b0;
    logic             pkt_lastword = 1'b0;
    logic [NT-1:0]    thread_done = '0;
    logic             fifo_rd;
    logic             fifowrite_out;
    logic             firstword_out;
    logic             enable_cpu_out;
    logic [SEL_W-1:0] thread_sel;
    logic [NT-1:0]    thread_busy;
    logic             all_busy;
    logic [CNT_W-1:0] pkt_count;

    infifo_thread_scheduler #(.SEL_W(SEL_W), .NUM_THREADS(NT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_lastword(pkt_lastword),
        .thread_done(thread_done), .fifo_rd(fifo_rd), .fifowrite_out(fifowrite_out),
        .firstword_out(firstword_out), .enable_cpu_out(enable_cpu_out),
        .thread_sel(thread_sel), .thread_busy(thread_busy), .all_busy(all_busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic last;
        int   gap_after;
    } word_t;

    typedef struct {
        logic [SEL_W-1:0] thr;
        logic             first;
    } wr_t;

    word_t            src[$];
    wr_t              exp_wr[$];
    logic [SEL_W-1:0] exp_en[$];
    int n_checks = 0;
    int n_fails = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int gap_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        wr_t w;
        cyc++;
        check_eq("rd_eq_wr", 32'(fifo_rd), 32'(fifowrite_out));
        if (!pkt_valid)
            check_eq("gap_quiet", 32'({fifo_rd, fifowrite_out, firstword_out}), 32'h0);
        if (fifowrite_out) begin
            if (exp_wr.size() == 0) begin
                check_eq("wr_unexpected", 32'h1, 32'h0);
            end else begin
                w = exp_wr.pop_front();
                check_eq("wr_thread", 32'(thread_sel), 32'(w.thr));
                check_eq("wr_first", 32'(firstword_out), 32'(w.first));
            end
            last_wr_cyc = cyc;
        end else begin
            check_eq("first_no_wr", 32'(firstword_out), 32'h0);
        end
        if (enable_cpu_out) begin
            if (exp_en.size() == 0) begin
                check_eq("en_unexpected", 32'h1, 32'h0);
            end else begin
                check_eq("en_thread", 32'(thread_sel), 32'(exp_en.pop_front()));
                check_eq("en_latency", cyc - last_wr_cyc, 32'h1);
            end
        end
    endtask

    task automatic drive();
        if (src.size() == 0 || gap_cnt > 0) begin
            pkt_valid    = 1'b0;
            pkt_lastword = 1'b0;
            if (gap_cnt > 0) gap_cnt--;
        end else begin
            pkt_valid    = 1'b1;
            pkt_lastword = src[0].last;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        if (fifo_rd && src.size() > 0) begin
            gap_cnt = src[0].gap_after;
            void'(src.pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic send_pkt(input int n, input int gap, input logic [SEL_W-1:0] thr,
                            input int n_wr, input bit want_en);
        word_t wd;
        wr_t   w;
        for (int i = 0; i < n; i++) begin
            wd.last      = (i == n - 1);
            wd.gap_after = (i == 0) ? gap : 0;
            src.push_back(wd);
        end
        for (int i = 0; i < n_wr; i++) begin
            w.thr   = thr;
            w.first = (i == 0);
            exp_wr.push_back(w);
        end
        if (want_en) exp_en.push_back(thr);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((src.size() > 0 || exp_wr.size() > 0 || exp_en.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check_eq("drain_timeout", 32'h0, 32'h1);
    endtask

    task automatic pulse_done(input logic [NT-1:0] mask);
        thread_done = mask;
        tick();
        thread_done = '0;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_sel", 32'(thread_sel), 32'h0);
        check_eq("rst_busy", 32'(thread_busy), 32'h0);
        check_eq("rst_all_busy", 32'(all_busy), 32'h0);
        check_eq("rst_count", pkt_count, 32'h0);
        check_eq("rst_strobes", 32'({fifo_rd, fifowrite_out, firstword_out, enable_cpu_out}), 32'h0);
        reset = 1'b0;

        // 4-word packet, continuous valid
        send_pkt(4, 0, 3'd0, 4, 1'b1);
        wait_drain(50);
        check_eq("p1_busy", 32'(thread_busy), 32'h01);
        check_eq("p1_count", pkt_count, 32'h1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst2_busy", 32'(thread_busy), 32'h0);

        // eight single-word packets back to back
        for (int t = 0; t < NT; t++) send_pkt(1, 0, SEL_W'(t), 1, 1'b1);
        wait_drain(100);
        check_eq("rr_busy", 32'(thread_busy), 32'hFF);
        check_eq("rr_all_busy", 32'(all_busy), 32'h1);
        check_eq("rr_count", pkt_count, 32'h8);

        // ninth packet stalls until thread 5 is released
        send_pkt(2, 0, 3'd5, 2, 1'b1);
        repeat (5) begin
            tick();
            check_eq("stall_rd", 32'(fifo_rd), 32'h0);
        end
        pulse_done(8'h20);
        check_eq("done5_busy", 32'(thread_busy), 32'hDF);
        check_eq("done5_all_busy", 32'(all_busy), 32'h0);
        tick();
        check_eq("sel_after_done", 32'(thread_sel), 32'h5);
        wait_drain(50);
        check_eq("p9_busy", 32'(thread_busy), 32'hFF);
        check_eq("p9_count", pkt_count, 32'h9);

        // 3-word packet with a 2-cycle valid gap after word 1
        pulse_done(8'h04);
        check_eq("done2_busy", 32'(thread_busy), 32'hFB);
        send_pkt(3, 2, 3'd2, 3, 1'b1);
        wait_drain(50);
        check_eq("gap_busy", 32'(thread_busy), 32'hFF);
        check_eq("gap_count", pkt_count, 32'd10);

        // done[0] coincides with dispatch to thread 0: set wins
        pulse_done(8'h01);
        send_pkt(1, 0, 3'd0, 1, 1'b1);
        k = 0;
        while (!enable_cpu_out && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check_eq("en_timeout", 32'h0, 32'h1);
        pulse_done(8'h01);
        check_eq("set_wins_busy", 32'(thread_busy), 32'hFF);
        check_eq("set_wins_count", pkt_count, 32'd11);
        check_eq("set_wins_drained", 32'(exp_en.size()), 32'h0);

        // done on a free thread is ignored; multiple dones clear together
        pulse_done(8'h08);
        check_eq("done3_busy", 32'(thread_busy), 32'hF7);
        pulse_done(8'h08);
        check_eq("done3_free_ignored", 32'(thread_busy), 32'hF7);
        pulse_done(8'hF7);
        check_eq("multi_done_busy", 32'(thread_busy), 32'h00);

        // reset in XFER after two words (thread 3 was granted while idle)
        send_pkt(4, 0, 3'd3, 2, 1'b0);
        k = 0;
        while (exp_wr.size() > 1 && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check_eq("xfer_timeout", 32'h0, 32'h1);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_words", 32'(exp_wr.size()), 32'h0);
        check_eq("mid_rst_strobes", 32'({fifo_rd, fifowrite_out, firstword_out, enable_cpu_out}), 32'h0);
        check_eq("mid_rst_busy", 32'(thread_busy), 32'h0);
        check_eq("mid_rst_sel", 32'(thread_sel), 32'h0);
        check_eq("mid_rst_count", pkt_count, 32'h0);
        src.delete();
        gap_cnt = 0;
        pkt_valid = 1'b0;
        pkt_lastword = 1'b0;
        reset = 1'b0;
        send_pkt(1, 0, 3'd0, 1, 1'b1);
        wait_drain(50);
        check_eq("post_rst_busy", 32'(thread_busy), 32'h01);
        check_eq("post_rst_count", pkt_count, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
